baud_gen_frac: RTL and testbench

- Parametrised successor to the fixed-divisor baud timer.
- Produces an oversample tick (o_s_tick) from a runtime-programmable fractional divisor, and a bit tick (o_b_tick) every OVS oversample ticks.
- Adds enable/freeze, phase resync for RX start-bit alignment, and glitch-free divisor reconfiguration applied only at a period boundary.
- Sits between the register interface and the UART TX/RX engines.

---
 rtl/baud_pkg.sv | 13 +
 rtl/baud_frac_div.sv | 33 +++
 rtl/baud_gen_frac.sv | 57 +++++
 tb/tb_baud_gen_frac.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/baud_pkg.sv
// baud_pkg: shared widths, config record and divisor clamp for the fractional baud generator
package baud_pkg;
  localparam int DIV_W = 16;
  localparam int FRAC_W = 4;
  localparam int MIN_DIV = 2;
  typedef struct packed {
    logic [DIV_W-1:0] div_int;
    logic [FRAC_W-1:0] div_frac;
  } baud_cfg_t;
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    return (d < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : d;
  endfunction
endpackage

// File: rtl/baud_frac_div.sv
// baud_frac_div: fractional clock divider producing one wrap pulse per oversample period
module baud_frac_div
  import baud_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      en,
  input  logic      sync,
  input  logic      clr,
  input  baud_cfg_t cfg,
  output logic      wrap
);
  logic [DIV_W-1:0] cnt;
  logic [FRAC_W-1:0] acc;
  logic carry;
  logic [DIV_W:0] period;
  // >= rather than == keeps a divisor shrunk while frozen from running cnt past the period
  always_comb begin
    period = {1'b0, cfg.div_int} + (DIV_W+1)'(carry);
    wrap = en && !sync && (({1'b0, cnt} + (DIV_W+1)'(1)) >= period);
  end
  always_ff @(posedge clk) begin
    if (!rst_n || sync) begin
      cnt <= '0;
      acc <= '0;
      carry <= 1'b0;
    end else begin
      if (en) cnt <= wrap ? '0 : cnt + DIV_W'(1);
      if (clr) {carry, acc} <= '0;
      else if (wrap) {carry, acc} <= {1'b0, acc} + {1'b0, cfg.div_frac};
    end
  end
endmodule

// File: rtl/baud_gen_frac.sv
// baud_gen_frac: oversample and bit tick generator with shadowed fractional divisor
module baud_gen_frac #(
  parameter int DIV_W = baud_pkg::DIV_W,
  parameter int FRAC_W = baud_pkg::FRAC_W,
  parameter int OVS = 16,
  parameter int RST_DIV_INT = 326,
  parameter int RST_DIV_FRAC = 0
) (
  input  logic                    i_clk,
  input  logic                    i_br_rst_n,
  input  logic                    i_en,
  input  logic                    i_sync,
  input  logic                    i_cfg_we,
  input  logic [DIV_W-1:0]        i_div_int,
  input  logic [FRAC_W-1:0]       i_div_frac,
  output logic                    o_s_tick,
  output logic                    o_b_tick,
  output logic [$clog2(OVS)-1:0]  o_ovs_cnt,
  output logic                    o_cfg_pend
);
  import baud_pkg::*;
  localparam int OW = $clog2(OVS);
  localparam baud_cfg_t RST_CFG = {DIV_W'(RST_DIV_INT), FRAC_W'(RST_DIV_FRAC)};
  baud_cfg_t active, shadow;
  logic wrap, apply, last;
  always_comb begin
    apply = o_cfg_pend && (wrap || i_sync || !i_en);
    last = o_ovs_cnt == OW'(OVS-1);
  end
  baud_frac_div u_div (
    .clk   (i_clk),
    .rst_n (i_br_rst_n),
    .en    (i_en),
    .sync  (i_sync),
    .clr   (apply),
    .cfg   (active),
    .wrap  (wrap)
  );
  // a write on an apply edge lands in the shadow and stays pending for the next apply point
  always_ff @(posedge i_clk) begin
    if (!i_br_rst_n) begin
      active <= RST_CFG;
      shadow <= RST_CFG;
      o_cfg_pend <= 1'b0;
      o_ovs_cnt <= '0;
      o_s_tick <= 1'b0;
      o_b_tick <= 1'b0;
    end else begin
      if (apply) active <= shadow;
      if (i_cfg_we) shadow <= {clamp_div(i_div_int), i_div_frac};
      o_cfg_pend <= i_cfg_we || (o_cfg_pend && !apply);
      o_s_tick <= wrap;
      o_b_tick <= wrap && last;
      o_ovs_cnt <= i_sync ? '0 : wrap ? (last ? '0 : o_ovs_cnt + OW'(1)) : o_ovs_cnt;
    end
  end
endmodule

// File: tb/tb_baud_gen_frac.sv
// tb_baud_gen_frac: directed stimulus with a tick-level reference model checked every cycle
module tb_baud_gen_frac;
  localparam int OVS = 16;
  logic clk = 0, rst_n = 0, en = 0, sync = 0, we = 0;
  logic [15:0] di = 0;
  logic [3:0] df = 0;
  logic s_tick, b_tick, pend;
  logic [3:0] ovs;
  int checks = 0, errors = 0;
  int m_div, m_frac, m_sdiv, m_sfrac, m_el, m_k, m_ovs;
  bit m_pend, m_s, m_b, m_ap, mon = 0;
  int t, n, tot;
  int p[0:32];

  always #5 clk = ~clk;

  baud_gen_frac dut (
    .i_clk      (clk),
    .i_br_rst_n (rst_n),
    .i_en       (en),
    .i_sync     (sync),
    .i_cfg_we   (we),
    .i_div_int  (di),
    .i_div_frac (df),
    .o_s_tick   (s_tick),
    .o_b_tick   (b_tick),
    .o_ovs_cnt  (ovs),
    .o_cfg_pend (pend)
  );

  // length of the k-th period since the last clear: integer part plus the fractional carry due so far
  function automatic int period_now();
    return m_div + (m_k == 0 ? 0 : (m_k * m_frac) / 16 - ((m_k - 1) * m_frac) / 16);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_div = 326; m_frac = 0; m_sdiv = 326; m_sfrac = 0; m_pend = 0;
      m_el = 0; m_k = 0; m_ovs = 0; m_s = 0; m_b = 0;
    end else begin
      m_ap = 0; m_s = 0; m_b = 0;
      if (sync) begin
        m_el = 0; m_k = 0; m_ovs = 0; m_ap = m_pend;
      end else if (en) begin
        m_el++;
        if (m_el == period_now()) begin
          m_s = 1; m_b = (m_ovs == OVS - 1); m_ovs = (m_ovs + 1) % OVS;
          m_el = 0; m_k++; m_ap = m_pend;
        end
      end else m_ap = m_pend;
      if (m_ap) begin
        m_div = m_sdiv; m_frac = m_sfrac; m_k = 0; m_pend = 0;
      end
      if (we) begin
        m_sdiv = (di < 2) ? 2 : int'(di); m_sfrac = int'(df); m_pend = 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (mon) begin
    chk("model_s_tick", int'(s_tick), int'(m_s));
    chk("model_b_tick", int'(b_tick), int'(m_b));
    chk("model_ovs_cnt", int'(ovs), m_ovs);
    chk("model_cfg_pend", int'(pend), int'(m_pend));
  end

  task automatic wait_tick(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!s_tick && cyc < 1000);
    if (!s_tick) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout no o_s_tick within %0d cycles", cyc);
    end
  endtask

  // called right after a tick (cnt=0): two frozen edges capture then apply the divisor
  task automatic cfg_frozen(input int d, input int f);
    en = 0; we = 1; di = 16'(d); df = 4'(f);
    @(negedge clk);
    we = 0;
    @(negedge clk);
    en = 1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    mon = 1;
    chk("rst_s_tick", int'(s_tick), 0);
    chk("rst_b_tick", int'(b_tick), 0);
    chk("rst_ovs", int'(ovs), 0);
    chk("rst_pend", int'(pend), 0);
    rst_n = 1;
    cfg_frozen(10, 0);
    tot = 0;
    for (int i = 0; i < 16; i++) begin
      wait_tick(t);
      tot += t;
      chk("t1_period", t, 10);
      chk("t1_b_tick", int'(b_tick), int'(i == 15));
      chk("t1_ovs", int'(ovs), (i + 1) % 16);
    end
    chk("t1_bit_cycles", tot, 160);

    cfg_frozen(3, 8);
    for (int i = 0; i <= 32; i++) begin
      wait_tick(t);
      p[i] = t;
    end
    chk("t2_p0", p[0], 3);
    chk("t2_p1", p[1], 3);
    chk("t2_p2", p[2], 4);
    chk("t2_p3", p[3], 3);
    chk("t2_p4", p[4], 4);
    tot = 0;
    for (int i = 1; i <= 32; i++) tot += p[i];
    chk("t2_sum32", tot, 112);

    cfg_frozen(10, 0);
    wait_tick(t);
    chk("t3_pre", t, 10);
    n = 0;
    repeat (4) begin @(negedge clk); n++; end
    en = 0;
    repeat (7) begin @(negedge clk); n++; end
    en = 1;
    wait_tick(t);
    chk("t3_frozen_period", n + t, 17);
    wait_tick(t);
    chk("t3_after", t, 10);

    n = 0;
    repeat (3) begin @(negedge clk); n++; end
    we = 1; di = 20;
    @(negedge clk); n++;
    we = 0;
    @(negedge clk); n++;
    we = 1; di = 25;
    @(negedge clk); n++;
    we = 0;
    chk("t4_pend_set", int'(pend), 1);
    wait_tick(t);
    chk("t4_cur_period", n + t, 10);
    chk("t4_pend_clr", int'(pend), 0);
    wait_tick(t);
    chk("t4_new1", t, 25);
    wait_tick(t);
    chk("t4_new2", t, 25);

    for (int i = 0; i < 40 && ovs != 9; i++) wait_tick(t);
    chk("t5_reach9", int'(ovs), 9);
    repeat (5) @(negedge clk);
    sync = 1;
    @(negedge clk);
    sync = 0;
    chk("t5_sync_ovs", int'(ovs), 0);
    chk("t5_sync_notick", int'(s_tick), 0);
    wait_tick(t);
    chk("t5_first", t, 25);
    chk("t5_b_first", int'(b_tick), 0);
    for (int i = 1; i < 16; i++) begin
      wait_tick(t);
      chk("t5_b_tick", int'(b_tick), int'(i == 15));
    end

    we = 1; di = 0;
    @(negedge clk);
    we = 0;
    wait_tick(t);
    chk("t6_old_period", t + 1, 25);
    wait_tick(t);
    chk("t6_clamp1", t, 2);
    wait_tick(t);
    chk("t6_clamp2", t, 2);
    we = 1; di = 50;
    @(negedge clk);
    we = 0;
    chk("t6_pend", int'(pend), 1);
    rst_n = 0;
    @(negedge clk);
    chk("t6_rst_s", int'(s_tick), 0);
    chk("t6_rst_b", int'(b_tick), 0);
    chk("t6_rst_ovs", int'(ovs), 0);
    chk("t6_rst_pend", int'(pend), 0);
    rst_n = 1;
    wait_tick(t);
    chk("t6_rst_period", t, 326);
    @(negedge clk);
    mon = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
